// File: rtl/nand_bus_pkg.sv
// Shared definitions for the NAND bus timing engine: opcodes, FSM states
// and the NAND command bytes issued by the upstream sequencer.
package nand_bus_pkg;

  localparam logic [2:0] OP_CMD    = 3'd0;
  localparam logic [2:0] OP_ADDR   = 3'd1;
  localparam logic [2:0] OP_WDATA  = 3'd2;
  localparam logic [2:0] OP_RDATA  = 3'd3;
  localparam logic [2:0] OP_WAITRB = 3'd4;

  localparam logic [7:0] CMD_READ1       = 8'h00;
  localparam logic [7:0] CMD_PROGRAM     = 8'h80;
  localparam logic [7:0] CMD_PROGCONFIRM = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOW,
    S_WHIGH,
    S_RLOW,
    S_RHIGH,
    S_TWBW,
    S_WRB,
    S_NOP
  } state_t;

endpackage

// File: rtl/nand_rb_sync.sv
// Two-flop synchronizer bringing the asynchronous flash ready/busy line
// into the clk domain; reset reads as "busy".
module nand_rb_sync (
  input  logic clk,
  input  logic rst,
  input  logic rb,
  output logic rb_sync
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= 1'b0;
      rb_sync <= 1'b0;
    end else begin
      meta    <= rb;
      rb_sync <= meta;
    end
  end

endmodule

// File: rtl/nand_bus_engine.sv
// NAND pin timing engine: turns single-byte bus operations into CLE/ALE/WE#/
// RE#/IO waveforms and returns read bytes. All pin outputs are registered.
module nand_bus_engine
  import nand_bus_pkg::*;
#(
  parameter int unsigned TWP  = 2,
  parameter int unsigned TWH  = 1,
  parameter int unsigned TRP  = 2,
  parameter int unsigned TREH = 1,
  parameter int unsigned TWB  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [7:0] op_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  inout  wire  [7:0] F_IO,
  output logic       F_CLE,
  output logic       F_ALE,
  output logic       F_WEN,
  output logic       F_REN,
  input  logic       F_RB
);

  localparam logic [7:0] TWP_M1  = 8'(TWP - 1);
  localparam logic [7:0] TWH_M1  = 8'(TWH - 1);
  localparam logic [7:0] TRP_M1  = 8'(TRP - 1);
  localparam logic [7:0] TREH_M1 = 8'(TREH - 1);
  localparam logic [7:0] TWB_M1  = 8'(TWB - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] io_out;
  logic       io_oe;
  logic       rb_sync;
  logic       to_idle;

  nand_rb_sync u_rb_sync (
    .clk     (clk),
    .rst     (rst),
    .rb      (F_RB),
    .rb_sync (rb_sync)
  );

  // The bus is released (high-Z) whenever no write is in progress.
  assign F_IO = io_oe ? io_out : 8'bz;

  assign to_idle = ((state == S_WHIGH || state == S_RHIGH) && cnt == 8'd0)
                || (state == S_WRB && rb_sync)
                || (state == S_NOP);

  // NOTE: every register here uses <= so all updates on an edge see the
  // pre-edge values; the trailing to_idle block relies on last-write-wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      io_out   <= 8'd0;
      io_oe    <= 1'b0;
      op_ready <= 1'b1;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
      F_CLE    <= 1'b0;
      F_ALE    <= 1'b0;
      F_WEN    <= 1'b1;
      F_REN    <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: if (op_valid) begin
          op_ready <= 1'b0;
          busy     <= 1'b1;
          case (op_code)
            OP_CMD, OP_ADDR, OP_WDATA: begin
              state  <= S_WLOW;
              cnt    <= TWP_M1;
              F_WEN  <= 1'b0;
              F_CLE  <= (op_code == OP_CMD);
              F_ALE  <= (op_code == OP_ADDR);
              io_oe  <= 1'b1;
              io_out <= op_data;
            end
            OP_RDATA: begin
              state <= S_RLOW;
              cnt   <= TRP_M1;
              F_REN <= 1'b0;
            end
            OP_WAITRB: begin
              state <= S_TWBW;
              cnt   <= TWB_M1;
            end
            default: state <= S_NOP;
          endcase
        end
        S_WLOW: if (cnt == 8'd0) begin
          state <= S_WHIGH;
          cnt   <= TWH_M1;
          F_WEN <= 1'b1;
        end else begin
          cnt <= cnt - 8'd1;
        end
        // Data is captured on the same edge that raises RE#.
        S_RLOW: if (cnt == 8'd0) begin
          state    <= S_RHIGH;
          cnt      <= TREH_M1;
          F_REN    <= 1'b1;
          rd_data  <= F_IO;
          rd_valid <= 1'b1;
        end else begin
          cnt <= cnt - 8'd1;
        end
        S_WHIGH, S_RHIGH: if (cnt != 8'd0) cnt <= cnt - 8'd1;
        S_TWBW: if (cnt == 8'd0) state <= S_WRB;
                else cnt <= cnt - 8'd1;
        default: ;
      endcase

      if (to_idle) begin
        state    <= S_IDLE;
        F_CLE    <= 1'b0;
        F_ALE    <= 1'b0;
        io_oe    <= 1'b0;
        op_ready <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nand_bus_engine.sv
// Self-checking bench for nand_bus_engine: table-driven vectors, hand-written
// reset/WAITRB sequences and random operations against a behavioural model.
module tb_nand_bus_engine;

  localparam int TWP = 2, TWH = 1, TRP = 2, TREH = 1, TWB = 4;
  localparam logic [2:0] C_CMD = 3'd0, C_ADDR = 3'd1, C_WDATA = 3'd2,
                         C_RDATA = 3'd3, C_WAITRB = 3'd4;

  typedef struct {
    int occ; int wen_lo; int ren_lo; int cle_n; int ale_n; int rv_n; int rv_at;
  } exp_t;

  typedef struct {
    int occ; int wen_lo; int ren_lo; int cle_n; int ale_n; int rv_n; int rv_at;
    int io_bad; int overlap; int busy_bad; int timeout;
  } obs_t;

  typedef struct {
    logic [2:0] code; logic [7:0] data; logic [7:0] fbyte; exp_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  wire  [7:0] f_io;
  logic       f_cle, f_ale, f_wen, f_ren;
  logic       f_rb;

  int n_checks = 0;
  int n_err    = 0;

  // Flash model: drives IO while RE# is low, latches on the rising WE# edge.
  logic [7:0] flash_byte = 8'h00;
  logic [7:0] flash_cmd  = 8'h00;
  logic [7:0] a0 = 8'h00, a1 = 8'h00, a2 = 8'h00;
  logic [7:0] last_rd = 8'h00;

  assign f_io = (!f_ren) ? flash_byte : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (f_io[g]);
  end

  always @(posedge f_wen) begin
    if (f_cle) flash_cmd <= f_io;
    if (f_ale) begin
      a2 <= a1;
      a1 <= a0;
      a0 <= f_io;
    end
  end

  always #5 clk = ~clk;

  nand_bus_engine #(.TWP(TWP), .TWH(TWH), .TRP(TRP), .TREH(TREH), .TWB(TWB)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .op_data  (op_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .F_IO     (f_io),
    .F_CLE    (f_cle),
    .F_ALE    (f_ale),
    .F_WEN    (f_wen),
    .F_REN    (f_ren),
    .F_RB     (f_rb)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int occ, wen, ren, cle, ale, rvn, rvat);
    exp_t e;
    e.occ = occ; e.wen_lo = wen; e.ren_lo = ren; e.cle_n = cle;
    e.ale_n = ale; e.rv_n = rvn; e.rv_at = rvat;
    return e;
  endfunction

  // Reference: what each operation should look like, from the timing rules.
  function automatic exp_t model(input logic [2:0] code);
    case (code)
      C_CMD:    return mk(TWP + TWH, TWP, 0, TWP + TWH, 0, 0, 0);
      C_ADDR:   return mk(TWP + TWH, TWP, 0, 0, TWP + TWH, 0, 0);
      C_WDATA:  return mk(TWP + TWH, TWP, 0, 0, 0, 0, 0);
      C_RDATA:  return mk(TRP + TREH, 0, TRP, 0, 0, 1, TRP + 1);
      C_WAITRB: return mk(TWB + 1, 0, 0, 0, 0, 0, 0);
      default:  return mk(1, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  // Called at a negedge while the engine is idle; returns at the negedge of
  // the first idle cycle afterwards. rb_low>0 raises F_RB in that cycle.
  task automatic run_op(input logic [2:0] code, input logic [7:0] data,
                        input logic [7:0] fbyte, input int rb_low,
                        output obs_t o, output time acc);
    int k;
    bit is_wr;
    o = '{default: 0};
    is_wr = (code == C_CMD || code == C_ADDR || code == C_WDATA);
    flash_byte = fbyte;
    op_valid = 1'b1;
    op_code  = code;
    op_data  = data;
    @(posedge clk);
    acc = $time;
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'($urandom);
    op_data  = 8'($urandom);
    k = 0;
    while (!op_ready && k < 300) begin
      k++;
      if (k == rb_low) f_rb = 1'b1;
      o.occ++;
      if (!f_wen) o.wen_lo++;
      if (!f_ren) o.ren_lo++;
      if (f_cle) o.cle_n++;
      if (f_ale) o.ale_n++;
      if (rd_valid) begin
        o.rv_n++;
        o.rv_at = k;
      end
      if (is_wr) begin
        if (f_io !== data) o.io_bad++;
      end else if (f_ren && f_io !== 8'hFF) o.io_bad++;
      if ((!f_wen && !f_ren) || (f_cle && f_ale)) o.overlap++;
      if (!busy) o.busy_bad++;
      @(negedge clk);
    end
    o.timeout = (k >= 300);
    if (code == C_RDATA) last_rd = fbyte;
  endtask

  task automatic compare(input string tag, input obs_t o, input exp_t e);
    check({tag, " timeout"}, o.timeout, 0);
    check({tag, " occupancy"}, o.occ, e.occ);
    check({tag, " wen_low"}, o.wen_lo, e.wen_lo);
    check({tag, " ren_low"}, o.ren_lo, e.ren_lo);
    check({tag, " cle_cycles"}, o.cle_n, e.cle_n);
    check({tag, " ale_cycles"}, o.ale_n, e.ale_n);
    check({tag, " rd_valid_count"}, o.rv_n, e.rv_n);
    check({tag, " rd_valid_cycle"}, o.rv_at, e.rv_at);
    check({tag, " io_bad_cycles"}, o.io_bad, 0);
    check({tag, " strobe_overlap"}, o.overlap, 0);
    check({tag, " busy_low"}, o.busy_bad, 0);
    check({tag, " rd_data"}, rd_data, last_rd);
    check({tag, " io_released"}, f_io, 8'hFF);
    check({tag, " idle_rd_valid"}, rd_valid, 0);
  endtask

  initial begin
    vec_t vecs[12];
    time  acc_t[12];
    obs_t o;
    time  t;
    logic [2:0] c;
    logic [7:0] d;

    vecs[0]  = '{C_CMD,    8'h80, 8'h00, mk(3, 2, 0, 3, 0, 0, 0)};
    vecs[1]  = '{C_ADDR,   8'h12, 8'h00, mk(3, 2, 0, 0, 3, 0, 0)};
    vecs[2]  = '{C_ADDR,   8'h34, 8'h00, mk(3, 2, 0, 0, 3, 0, 0)};
    vecs[3]  = '{C_ADDR,   8'h01, 8'h00, mk(3, 2, 0, 0, 3, 0, 0)};
    vecs[4]  = '{C_WDATA,  8'h5A, 8'h00, mk(3, 2, 0, 0, 0, 0, 0)};
    vecs[5]  = '{C_RDATA,  8'h00, 8'hA5, mk(3, 0, 2, 0, 0, 1, 3)};
    vecs[6]  = '{3'd6,     8'h77, 8'h00, mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[7]  = '{C_WDATA,  8'hC3, 8'h00, mk(3, 2, 0, 0, 0, 0, 0)};
    vecs[8]  = '{C_RDATA,  8'h00, 8'h3C, mk(3, 0, 2, 0, 0, 1, 3)};
    vecs[9]  = '{C_WAITRB, 8'h00, 8'h00, mk(5, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{3'd7,     8'h00, 8'h00, mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{3'd5,     8'hFF, 8'h00, mk(1, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1;
    f_rb = 1'b1;
    op_valid = 1'b0;
    op_code = 3'd0;
    op_data = 8'd0;
    repeat (3) @(negedge clk);
    check("reset op_ready", op_ready, 1);
    check("reset busy", busy, 0);
    check("reset F_WEN", f_wen, 1);
    check("reset F_REN", f_ren, 1);
    check("reset F_CLE", f_cle, 0);
    check("reset F_ALE", f_ale, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset F_IO", f_io, 8'hFF);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous abort in the middle of a write strobe.
    op_valid = 1'b1;
    op_code  = C_CMD;
    op_data  = 8'h80;
    @(negedge clk);
    op_valid = 1'b0;
    check("abort pre F_WEN", f_wen, 0);
    check("abort pre F_CLE", f_cle, 1);
    #1 rst = 1'b1;
    #1;
    check("abort F_WEN", f_wen, 1);
    check("abort F_CLE", f_cle, 0);
    check("abort F_IO", f_io, 8'hFF);
    check("abort op_ready", op_ready, 1);
    check("abort busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    check("abort rd_valid", rd_valid, 0);
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].code, vecs[i].data, vecs[i].fbyte, 0, o, t);
      acc_t[i] = t;
      compare($sformatf("vec%0d", i), o, vecs[i].e);
      if (i == 0) check("flash latched PROGRAM", flash_cmd, 8'h80);
    end
    check("flash address", {a0[1:0], a1, a2}, 18'h01_3412);
    check("addr gap 1", int'((acc_t[2] - acc_t[1]) / 10), TWP + TWH + 1);
    check("addr gap 2", int'((acc_t[3] - acc_t[2]) / 10), TWP + TWH + 1);

    // WAITRB while the flash reports busy for 20 cycles.
    f_rb = 1'b0;
    @(negedge clk);
    run_op(C_WAITRB, 8'h00, 8'h00, 20, o, t);
    check("waitrb timeout", o.timeout, 0);
    check("waitrb busy >= 22", int'(o.occ >= 22), 1);
    check("waitrb release 2-3 after F_RB", int'(o.occ - 20 >= 2 && o.occ - 20 <= 3), 1);
    check("waitrb busy_low", o.busy_bad, 0);
    check("waitrb no strobes", o.wen_lo + o.ren_lo + o.cle_n + o.ale_n, 0);
    repeat (2) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      c = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      run_op(c, d, 8'($urandom), 0, o, t);
      compare($sformatf("rnd%0d op%0d", n, c), o, model(c));
      if (c == C_CMD)  check($sformatf("rnd%0d flash cmd", n), flash_cmd, d);
      if (c == C_ADDR) check($sformatf("rnd%0d flash addr byte", n), a0, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
